// File: rtl/nfc_ca_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nfc_ca_pkg                                                       |
// | Brief   : Shared types and constants for the NFC command/address sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nfc_ca_pkg;

  localparam int c_timerWidth = 4;

  localparam logic CA_CMD  = 1'b0;
  localparam logic CA_ADDR = 1'b1;

  localparam logic [3:0] c_weIdle = 4'b1111;
  localparam logic [3:0] c_reIdle = 4'b1111;

  localparam logic [c_timerWidth-1:0] c_timerOne = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WE_LOW  = 3'd2,
    ST_WE_HIGH = 3'd3,
    ST_HOLD    = 3'd4
  } caState_t;

  // Counter load value (cycles - 1); a zero override nibble falls back to the parameter.
  function automatic logic [c_timerWidth-1:0] timingLoad(
    input logic [c_timerWidth-1:0] nibble,
    input logic [c_timerWidth-1:0] paramCycles
  );
    logic [c_timerWidth-1:0] cycles;
    cycles = (nibble != '0) ? nibble : paramCycles;
    return cycles - c_timerOne;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nfc_ca_timing_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nfc_ca_timing_counter                                            |
// | Brief   : Loadable down-counter with zero flag shared by all timed states  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nfc_ca_timing_counter
  import nfc_ca_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iLoad,
  input  logic [c_timerWidth-1:0] iLoadValue,
  output logic [c_timerWidth-1:0] oCount,
  output logic                    oZero
);

  logic [c_timerWidth-1:0] r_count;

  // Saturates at zero so a stalled state simply sits on its final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= iLoadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - c_timerOne;
    end
  end

  assign oCount = r_count;
  assign oZero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/nfc_ca_latch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nfc_ca_latch_sequencer                                           |
// | Brief   : SDR CLE/ALE latch-cycle generator; one WE# pulse per CA byte.    |
// |           NFC_CA_TIMING_OVERRIDE_EN adds per-sequence iTimingOverride.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nfc_ca_latch_sequencer
  import nfc_ca_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int SetupCycles  = 2,
  parameter int WELowCycles  = 2,
  parameter int WEHighCycles = 2,
  parameter int HoldCycles   = 2
) (
  input  logic                      iSystemClock,
  input  logic                      iModuleReset,
  input  logic [NumberOfWays-1:0]   iTargetWay,
  input  logic                      iCAValid,
  output logic                      oCAReady,
  input  logic                      iCAType,
  input  logic [7:0]                iCAData,
  input  logic                      iCALast,
  output logic                      oCADone,
  output logic [7:0]                oPO_DQStrobe,
  output logic [31:0]               oPO_DQ,
  output logic [2*NumberOfWays-1:0] oPO_ChipEnable,
  output logic [3:0]                oPO_ReadEnable,
  output logic [3:0]                oPO_WriteEnable,
  output logic [3:0]                oPO_AddressLatchEnable,
  output logic [3:0]                oPO_CommandLatchEnable,
  output logic                      oDQSOutEnable,
  output logic                      oDQOutEnable
`ifdef NFC_CA_TIMING_OVERRIDE_EN
  ,
  input  logic [15:0]               iTimingOverride
`endif
);

  localparam logic [c_timerWidth-1:0] c_setupCyc  = c_timerWidth'(SetupCycles);
  localparam logic [c_timerWidth-1:0] c_weLowCyc  = c_timerWidth'(WELowCycles);
  localparam logic [c_timerWidth-1:0] c_weHighCyc = c_timerWidth'(WEHighCycles);
  localparam logic [c_timerWidth-1:0] c_holdCyc   = c_timerWidth'(HoldCycles);

  logic [15:0] w_override;
`ifdef NFC_CA_TIMING_OVERRIDE_EN
  assign w_override = iTimingOverride;
`else
  assign w_override = '0;
`endif

  logic [c_timerWidth-1:0] w_setupSel;
  logic [c_timerWidth-1:0] w_weLowSel;
  logic [c_timerWidth-1:0] w_weHighSel;
  logic [c_timerWidth-1:0] w_holdSel;

  assign w_setupSel  = timingLoad(w_override[3:0],   c_setupCyc);
  assign w_weLowSel  = timingLoad(w_override[7:4],   c_weLowCyc);
  assign w_weHighSel = timingLoad(w_override[11:8],  c_weHighCyc);
  assign w_holdSel   = timingLoad(w_override[15:12], c_holdCyc);

  caState_t                  r_state;
  logic                      r_ready;
  logic                      r_done;
  logic                      r_we;
  logic                      r_cle;
  logic                      r_ale;
  logic                      r_dqOe;
  logic                      r_type;
  logic                      r_last;
  logic [NumberOfWays-1:0]   r_way;
  logic [2*NumberOfWays-1:0] r_ceN;
  logic [7:0]                r_dq;
  logic [c_timerWidth-1:0]   r_setupM1;
  logic [c_timerWidth-1:0]   r_weLowM1;
  logic [c_timerWidth-1:0]   r_weHighM1;
  logic [c_timerWidth-1:0]   r_holdM1;

  logic                      w_accept;
  logic                      w_sameGroup;
  logic [2*NumberOfWays-1:0] w_ceSel;
  logic                      w_cntLoad;
  logic [c_timerWidth-1:0]   w_cntValue;
  logic [c_timerWidth-1:0]   w_cntCount;
  logic                      w_cntZero;

  assign w_accept    = iCAValid & r_ready;
  assign w_sameGroup = (iCAType == r_type) && (iTargetWay == r_way);
  assign w_ceSel     = {~iTargetWay, ~iTargetWay};

  // Counter reload mirrors every state transition taken below.
  always_comb begin
    w_cntLoad  = 1'b0;
    w_cntValue = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cntLoad  = 1'b1;
          w_cntValue = w_setupSel;
        end
      end
      ST_SETUP: begin
        if (w_cntZero) begin
          w_cntLoad  = 1'b1;
          w_cntValue = r_weLowM1;
        end
      end
      ST_WE_LOW: begin
        if (w_cntZero) begin
          w_cntLoad  = 1'b1;
          w_cntValue = r_weHighM1;
        end
      end
      ST_WE_HIGH: begin
        if (w_cntZero) begin
          if (r_last) begin
            w_cntLoad  = 1'b1;
            w_cntValue = r_holdM1;
          end else if (w_accept) begin
            w_cntLoad  = 1'b1;
            w_cntValue = w_sameGroup ? r_weLowM1 : r_setupM1;
          end
        end
      end
      default: begin
        w_cntLoad  = 1'b0;
        w_cntValue = '0;
      end
    endcase
  end

  nfc_ca_timing_counter u_timer (
    .clk        (iSystemClock),
    .rst_n      (iModuleReset),
    .iLoad      (w_cntLoad),
    .iLoadValue (w_cntValue),
    .oCount     (w_cntCount),
    .oZero      (w_cntZero)
  );

  always_ff @(posedge iSystemClock or negedge iModuleReset) begin
    if (!iModuleReset) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_we       <= 1'b1;
      r_cle      <= 1'b0;
      r_ale      <= 1'b0;
      r_dqOe     <= 1'b0;
      r_type     <= CA_CMD;
      r_last     <= 1'b0;
      r_way      <= '0;
      r_ceN      <= '1;
      r_dq       <= '0;
      r_setupM1  <= timingLoad('0, c_setupCyc);
      r_weLowM1  <= timingLoad('0, c_weLowCyc);
      r_weHighM1 <= timingLoad('0, c_weHighCyc);
      r_holdM1   <= timingLoad('0, c_holdCyc);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state    <= ST_SETUP;
            r_ready    <= 1'b0;
            r_type     <= iCAType;
            r_way      <= iTargetWay;
            r_last     <= iCALast;
            r_dq       <= iCAData;
            r_cle      <= (iCAType == CA_CMD);
            r_ale      <= (iCAType == CA_ADDR);
            r_ceN      <= w_ceSel;
            r_dqOe     <= 1'b1;
            r_we       <= 1'b1;
            r_setupM1  <= w_setupSel;
            r_weLowM1  <= w_weLowSel;
            r_weHighM1 <= w_weHighSel;
            r_holdM1   <= w_holdSel;
          end
        end
        ST_SETUP: begin
          if (w_cntZero) begin
            r_state <= ST_WE_LOW;
            r_we    <= 1'b0;
          end
        end
        ST_WE_LOW: begin
          if (w_cntZero) begin
            r_state <= ST_WE_HIGH;
            r_we    <= 1'b1;
            r_ready <= (r_weHighM1 == '0) && !r_last;
          end
        end
        ST_WE_HIGH: begin
          if (w_cntZero) begin
            if (r_last) begin
              r_state <= ST_HOLD;
              r_ready <= 1'b0;
            end else if (w_accept) begin
              r_ready <= 1'b0;
              r_type  <= iCAType;
              r_way   <= iTargetWay;
              r_last  <= iCALast;
              r_dq    <= iCAData;
              r_cle   <= (iCAType == CA_CMD);
              r_ale   <= (iCAType == CA_ADDR);
              r_ceN   <= w_ceSel;
              // Same latch type and way skips setup and pulses WE# straight away.
              if (w_sameGroup) begin
                r_state <= ST_WE_LOW;
                r_we    <= 1'b0;
              end else begin
                r_state <= ST_SETUP;
              end
            end
          end else if (w_cntCount == c_timerOne) begin
            r_ready <= !r_last;
          end
        end
        ST_HOLD: begin
          if (w_cntZero) begin
            r_state <= ST_IDLE;
            r_cle   <= 1'b0;
            r_ale   <= 1'b0;
            r_ceN   <= '1;
            r_dqOe  <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oCAReady               = r_ready;
  assign oCADone                = r_done;
  assign oPO_DQStrobe           = '0;
  assign oPO_DQ                 = {4{r_dq}};
  assign oPO_ChipEnable         = r_ceN;
  assign oPO_ReadEnable         = c_reIdle;
  assign oPO_WriteEnable        = {4{r_we}};
  assign oPO_AddressLatchEnable = {4{r_ale}};
  assign oPO_CommandLatchEnable = {4{r_cle}};
  assign oDQSOutEnable          = 1'b0;
  assign oDQOutEnable           = r_dqOe;

endmodule
`default_nettype wire

// File: tb/tb_nfc_ca_latch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_nfc_ca_latch_sequencer                                        |
// | Brief   : Scoreboard bench for the CA latch sequencer (WE# events, done).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nfc_ca_latch_sequencer;

  localparam int NW      = 4;
  localparam int P_SETUP = 2;
  localparam int P_WEL   = 2;
  localparam int P_WEH   = 2;
  localparam int P_HOLD  = 2;
`ifdef NFC_CA_TIMING_OVERRIDE_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            clk     = 1'b0;
  logic            rstN    = 1'b0;
  logic [NW-1:0]   way     = '0;
  logic            caValid = 1'b0;
  logic            caType  = 1'b0;
  logic [7:0]      caData  = '0;
  logic            caLast  = 1'b0;
  logic [15:0]     ovr     = '0;

  logic            caReady;
  logic            caDone;
  logic [7:0]      dqs;
  logic [31:0]     dq;
  logic [2*NW-1:0] ce;
  logic [3:0]      re;
  logic [3:0]      we;
  logic [3:0]      ale;
  logic [3:0]      cle;
  logic            dqsOe;
  logic            dqOe;

  nfc_ca_latch_sequencer #(
    .NumberOfWays (NW),
    .SetupCycles  (P_SETUP),
    .WELowCycles  (P_WEL),
    .WEHighCycles (P_WEH),
    .HoldCycles   (P_HOLD)
  ) dut (
    .iSystemClock           (clk),
    .iModuleReset           (rstN),
    .iTargetWay             (way),
    .iCAValid               (caValid),
    .oCAReady               (caReady),
    .iCAType                (caType),
    .iCAData                (caData),
    .iCALast                (caLast),
    .oCADone                (caDone),
    .oPO_DQStrobe           (dqs),
    .oPO_DQ                 (dq),
    .oPO_ChipEnable         (ce),
    .oPO_ReadEnable         (re),
    .oPO_WriteEnable        (we),
    .oPO_AddressLatchEnable (ale),
    .oPO_CommandLatchEnable (cle),
    .oDQSOutEnable          (dqsOe),
    .oDQOutEnable           (dqOe)
`ifdef NFC_CA_TIMING_OVERRIDE_EN
    ,
    .iTimingOverride        (ovr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int pick(input int nib, input int p);
    return (nib != 0) ? nib : p;
  endfunction

  typedef struct {
    logic          typ;
    logic [NW-1:0] way;
    logic [7:0]    data;
    int            fallCyc;
    int            lowLen;
    bit            setup;
  } weExp_t;

  weExp_t weQ[$];
  int     doneQ[$];

  // Reference model state: per-sequence timing and the earliest cycle ready may be seen.
  bit            inSeq   = 1'b0;
  logic          prevType = 1'b0;
  logic [NW-1:0] prevWay = '0;
  int            readyAt = 0;
  int            tS = P_SETUP, tWL = P_WEL, tWH = P_WEH, tH = P_HOLD;

  task automatic sendByte(input logic typ, input logic [NW-1:0] w, input logic [7:0] d,
                          input logic last, input logic [15:0] ov);
    int offer, n, acc, fall;
    bit newGroup;
    if (!inSeq) begin
      ovr = ov;
      tS  = pick(OVR_EN ? int'(ovr[3:0])   : 0, P_SETUP);
      tWL = pick(OVR_EN ? int'(ovr[7:4])   : 0, P_WEL);
      tWH = pick(OVR_EN ? int'(ovr[11:8])  : 0, P_WEH);
      tH  = pick(OVR_EN ? int'(ovr[15:12]) : 0, P_HOLD);
    end
    newGroup = !inSeq || (typ != prevType) || (w != prevWay);
    caValid = 1'b1; caType = typ; way = w; caData = d; caLast = last;
    offer = cyc;
    n = 0;
    while (caReady !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_bound", (n < 80), 1'b1);
    if (n < 80) begin
      acc = cyc;
      check("accept_cycle", acc, (offer > readyAt) ? offer : readyAt);
      fall = acc + 1 + (newGroup ? tS : 0);
      weQ.push_back('{typ, w, d, fall, tWL, newGroup});
      prevFall_upd(fall);
      prevType = typ;
      prevWay  = w;
      inSeq    = !last;
      if (last) begin
        doneQ.push_back(fall + tWL + tWH + tH);
        readyAt = fall + tWL + tWH + tH;
      end else begin
        readyAt = fall + tWL + tWH - 1;
      end
    end
    @(negedge clk);
    caValid = 1'b0;
  endtask

  int prevFall = 0;
  function automatic void prevFall_upd(input int f);
    prevFall = f;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((weQ.size() != 0 || doneQ.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", weQ.size() + doneQ.size(), 0);
  endtask

  // Monitor: pops an expectation on every WE# fall and every done pulse.
  logic          prevWe  = 1'b1;
  logic [31:0]   prevDq  = '0;
  logic [3:0]    prevCle = '0;
  logic [3:0]    prevAle = '0;
  logic [2*NW-1:0] prevCe = '1;
  int            lowCnt  = 0;
  int            expLow  = 0;

  always @(negedge clk) begin
    weExp_t e;
    int dc;
    if (!rstN) begin
      prevWe = 1'b1;
      lowCnt = 0;
    end else begin
      if (prevWe && we[0] == 1'b0) begin
        check("we_fall_expected", (weQ.size() != 0), 1'b1);
        if (weQ.size() != 0) begin
          e = weQ.pop_front();
          check("we_fall_cycle", cyc, e.fallCyc);
          check("we_all_low", we, 4'h0);
          check("cle_at_fall", cle, e.typ ? 4'h0 : 4'hF);
          check("ale_at_fall", ale, e.typ ? 4'hF : 4'h0);
          check("ce_at_fall", ce, {~e.way, ~e.way});
          check("dq_at_fall", dq, {4{e.data}});
          check("dqoe_at_fall", dqOe, 1'b1);
          if (e.setup) begin
            check("setup_stable", {prevDq, prevCle, prevAle, prevCe}, {dq, cle, ale, ce});
          end
          expLow = e.lowLen;
        end
        lowCnt = 1;
      end else if (we[0] == 1'b0) begin
        lowCnt++;
      end else if (!prevWe) begin
        check("we_low_len", lowCnt, expLow);
      end
      if (caDone) begin
        check("done_expected", (doneQ.size() != 0), 1'b1);
        if (doneQ.size() != 0) begin
          dc = doneQ.pop_front();
          check("done_cycle", cyc, dc);
        end
        check("idle_outputs", {ce, cle, ale, dqOe, caReady, we, re, dqs, dqsOe},
              {{(2*NW){1'b1}}, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 4'hF, 8'h00, 1'b0});
      end
      prevWe  = we[0];
      prevDq  = dq;
      prevCle = cle;
      prevAle = ale;
      prevCe  = ce;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] w;
    logic          t;
    logic [15:0]   ov;
    int            nb, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {we, re, cle, ale, ce, dq, dqOe, caReady, caDone, dqs, dqsOe},
          {4'hF, 4'hF, 4'h0, 4'h0, {(2*NW){1'b1}}, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_reset", caReady, 1'b1);
    readyAt = cyc;

    // Single command 0x70 on way 1
    sendByte(1'b0, 4'b0010, 8'h70, 1'b1, 16'h0);
    check("setup_entry", {cle, ale, dq, ce, we, dqOe, caReady},
          {4'hF, 4'h0, 32'h70707070, 8'hDD, 4'hF, 1'b1, 1'b0});
    drain();

    // Command then five addresses with valid held
    sendByte(1'b0, 4'b0001, 8'h00, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) sendByte(1'b1, 4'b0001, 8'(8'h10 + i), (i == 4), 16'h0);
    drain();

    // Address stream with a 3-cycle valid gap
    sendByte(1'b0, 4'b0100, 8'h80, 1'b0, 16'h0);
    sendByte(1'b1, 4'b0100, 8'hA1, 1'b0, 16'h0);
    n = 0;
    while (caReady !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {caReady, we, dq, ale}, {1'b1, 4'hF, 32'hA1A1A1A1, 4'hF});
      @(negedge clk);
    end
    sendByte(1'b1, 4'b0100, 8'hA2, 1'b1, 16'h0);
    drain();

    // Reset in the middle of WE# low
    sendByte(1'b0, 4'b1000, 8'hFF, 1'b1, 16'h0);
    n = 0;
    while (we[0] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rstN = 1'b0;
    #1;
    check("reset_mid_pulse", {we, cle, ale, ce, dqOe, caReady},
          {4'hF, 4'h0, 4'h0, {(2*NW){1'b1}}, 1'b0, 1'b0});
    weQ.delete();
    doneQ.delete();
    inSeq = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_release", caReady, 1'b1);
    readyAt = cyc;

`ifdef NFC_CA_TIMING_OVERRIDE_EN
    sendByte(1'b0, 4'b0001, 8'h5A, 1'b1, 16'h3450);
    drain();
`endif

    // Randomized sequences
    for (int s = 0; s < 25; s++) begin
      nb = $urandom_range(1, 6);
      w  = 4'(1 << $urandom_range(0, NW - 1));
      ov = ($urandom_range(0, 3) == 0) ? 16'h3450 : 16'($urandom);
      t  = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if (b > 0) begin
          t = ($urandom_range(0, 4) == 0) ? ~t : 1'b1;
          if ($urandom_range(0, 9) == 0) w = 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        sendByte(t, w, 8'($urandom), (b == nb - 1), ov);
      end
      idle($urandom_range(0, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
